// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder. It uses one 4-bit adder and feeds it one nibble
//   per clock, starting with the LSB nibble. The carry is registered between
//   nibbles. The result is returned through a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/cin valid           in_ready   accepting operands (IDLE)
//   a, b       WIDTH-bit operands      cin        carry into bit 0
//   out_valid  result valid (DONE)     out_ready  consumer takes result
//   sum        a+b+cin mod 2^WIDTH     cout       carry out of bit WIDTH-1
//   ovf        signed overflow         busy       nibble passes in progress
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one nibble added per clock, busy=1
// DONE  | result presented, out_valid=1 until out_ready

module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  // The low two bits of the bit offset are always zero, so the nibble index is shifted left by two.
  logic [IDX_W+1:0] w_base;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum_nib;
  logic             w_cout_nib;

  assign w_base  = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_base +: 4];
  assign w_b_nib = r_b[w_base +: 4];

  full_adder_4bit u_fa (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_sum_nib),
    .cout (w_cout_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 4] <= w_sum_nib;
          r_carry            <= w_cout_nib;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout_nib;
            // Signed overflow: the operands have the same sign and the result has the other sign.
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_nib[3] != r_a[WIDTH-1]);
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  localparam int NIB16 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 main instance
  logic        in_valid = 0, out_ready = 1, cin = 0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf, busy;
  logic [15:0] sum;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy));

  // WIDTH=4 instance
  logic       iv4 = 0, cin4 = 0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4, ov4, co4, of4, bz4;
  logic [3:0] s4;

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(ov4), .out_ready(1'b1),
    .sum(s4), .cout(co4), .ovf(of4), .busy(bz4));

  // WIDTH=32 instance
  logic        iv32 = 0, cin32 = 0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, ov32, co32, of32, bz32;
  logic [31:0] s32;

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(cin32), .out_valid(ov32), .out_ready(1'b1),
    .sum(s32), .cout(co32), .ovf(of32), .busy(bz32));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  // The DUT must be in IDLE when this is called. out_ready is 1, so the task returns after the edge that goes back to IDLE.
  task automatic run16(input string nm, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic [15:0] es, input logic ec, input logic eo);
    chk({nm, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    a = ia; b = ib; cin = ic; in_valid = 1;
    tick();                      // accepting edge
    in_valid = 0;
    a = ~ia; b = ~ib; cin = ~ic; // must be ignored during RUN
    chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
    repeat (NIB16 - 1) tick();
    chk({nm, "_early_valid"}, {31'b0, out_valid}, 32'd0);
    tick();
    chk({nm, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({nm, "_sum"}, {16'b0, sum}, {16'b0, es});
    chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ec});
    chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    tick();                      // DONE -> IDLE
  endtask

  vec_t vecs[7];
  logic [15:0] held;

  initial begin
    vecs[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 7; i++)
      run16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].esum, vecs[i].ecout, vecs[i].eovf);

    // Back-pressure: hold the result in DONE while the inputs change.
    out_ready = 0;
    a = 16'h1234; b = 16'h1111; cin = 0; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (NIB16) tick();
    chk("hold_enter_valid", {31'b0, out_valid}, 32'd1);
    chk("hold_enter_sum", {16'b0, sum}, 32'h2345);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0]; a = 16'hA5A5 ^ 16'(k); b = 16'h5A5A + 16'(k);
      tick();
      chk($sformatf("hold%0d_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      chk($sformatf("hold%0d_res", k), {14'b0, cout, ovf, sum}, 32'h2345);
    end
    // Release with in_valid already high. DONE must not accept it; IDLE accepts it on the following edge.
    a = 16'h0002; b = 16'h0003; cin = 0; in_valid = 1; out_ready = 1;
    tick();
    chk("hs_idle_in_ready", {31'b0, in_ready}, 32'd1);
    chk("hs_idle_out_valid", {31'b0, out_valid}, 32'd0);
    chk("hs_idle_sum_held", {16'b0, sum}, 32'h2345);
    tick();
    in_valid = 0;
    chk("hs_accept_busy", {31'b0, busy}, 32'd1);
    repeat (NIB16) tick();
    chk("hs_second_valid", {31'b0, out_valid}, 32'd1);
    chk("hs_second_sum", {16'b0, sum}, 32'h0005);
    tick();

    // Assert reset asynchronously in the middle of RUN.
    a = 16'hAAAA; b = 16'h5555; cin = 1; in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("arst_sum", {16'b0, sum}, 32'd0);
    chk("arst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_busy_valid", {30'b0, busy, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    tick();
    run16("post_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    // WIDTH=4: the result takes a single RUN cycle.
    a4 = 4'hF; b4 = 4'h1; cin4 = 0; iv4 = 1;
    tick();
    iv4 = 0;
    chk("w4_busy", {31'b0, bz4}, 32'd1);
    chk("w4_early_valid", {31'b0, ov4}, 32'd0);
    tick();
    chk("w4_valid", {31'b0, ov4}, 32'd1);
    chk("w4_res", {26'b0, co4, of4, s4}, {26'b0, 1'b1, 1'b0, 4'h0});
    tick();

    // WIDTH=32: eight passes.
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1; iv32 = 1;
    tick();
    iv32 = 0;
    repeat (7) tick();
    chk("w32_early_valid", {31'b0, ov32}, 32'd0);
    tick();
    chk("w32_valid", {31'b0, ov32}, 32'd1);
    chk("w32_sum", s32, 32'h0000_0001);
    chk("w32_cout_ovf", {30'b0, co32, of32}, 32'd2);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
